// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard and sequencing controller for the 5-stage MIPS core.
//   Every cycle it decides whether PC / IF latch hold, whether the ID/WB
//   stage inserts a bubble, and whether the IF latch is flushed. Sources:
//   load-use interlock, HI/LO occupancy after mult/div, taken-branch
//   squash, and the exit syscall ($v0 == 10) which halts the core.
//   Also counts interlock stall cycles (saturating).
//
// Ports
//   clk, clr             clock, synchronous active-high reset
//   id_read1_num/2_num   register numbers read by the ID instruction
//   id_is_md             ID holds mult/multu/div/divu
//   id_uses_hilo         ID holds mfhi/mflo/mthi/mtlo
//   id_is_syscall        ID holds syscall
//   v0_value             forwarded $v0 seen by the ID instruction
//   ex_mem_to_reg        EX holds a load
//   ex_write_num         EX destination register
//   ex_branch_taken      branch/jump resolved taken in EX
//   pc_stall, if_id_hold, id_bubble, if_flush   combinational controls
//   halted               registered, high while in HALT
//   stall_cycles         interlock stall cycle count
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  id_read1_num,
  input  logic [4:0]  id_read2_num,
  input  logic        id_is_md,
  input  logic        id_uses_hilo,
  input  logic        id_is_syscall,
  input  logic [31:0] v0_value,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_write_num,
  input  logic        ex_branch_taken,
  output logic        pc_stall,
  output logic        if_id_hold,
  output logic        id_bubble,
  output logic        if_flush,
  output logic        halted,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    HALT    = 2'd2
  } state_t;

  localparam logic [5:0] MD_LAT = 6'(MD_LATENCY);

  state_t      state, state_n;
  logic [5:0]  md_cnt, md_cnt_n;

  logic        lu;          // load-use interlock
  logic        md;          // HI/LO still owned by an in-flight mult/div
  logic        stall_req;
  logic        accepted;    // ID instruction advances this cycle
  logic        exit_sys;    // accepted exit syscall
  logic        count_stall;

  // ---------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------
  always_comb begin
    // $zero is never really written, so a load to r0 cannot create a hazard
    lu = ex_mem_to_reg && (ex_write_num != 5'd0) &&
         ((ex_write_num == id_read1_num) || (ex_write_num == id_read2_num));
    // a second mult/div also has to wait: it would overwrite HI/LO early
    md = (state == MD_BUSY) && (id_uses_hilo || id_is_md);
    stall_req = lu || md;
    // a squashed instruction is wrong-path and must have no side effects
    accepted  = (state != HALT) && !ex_branch_taken && !stall_req;
    exit_sys  = accepted && id_is_syscall && (v0_value == 32'd10);
  end

  // ---------------------------------------------------------------
  // Pipeline controls, priority HALT > branch > interlock
  // ---------------------------------------------------------------
  always_comb begin
    pc_stall   = 1'b0;
    if_id_hold = 1'b0;
    id_bubble  = 1'b0;
    if_flush   = 1'b0;
    if (clr) begin
      // all controls quiet while reset is applied
    end else if (state == HALT) begin
      pc_stall   = 1'b1;
      if_id_hold = 1'b1;
      id_bubble  = 1'b1;
    end else if (ex_branch_taken) begin
      // the branch overrides interlocks: the stalled instruction is wrong-path
      if_flush   = 1'b1;
      id_bubble  = 1'b1;
    end else if (stall_req) begin
      pc_stall   = 1'b1;
      if_id_hold = 1'b1;
      id_bubble  = 1'b1;
    end
  end

  // only genuine interlock cycles are counted; halt and squash cycles are not
  assign count_stall = !clr && (state != HALT) && !ex_branch_taken && stall_req;

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_n  = state;
    md_cnt_n = md_cnt;
    unique case (state)
      RUN: begin
        if (exit_sys) begin
          state_n = HALT;
        end else if (accepted && id_is_md) begin
          state_n  = MD_BUSY;
          md_cnt_n = MD_LAT;
        end
      end
      MD_BUSY: begin
        if (exit_sys) begin
          // the halt wins over any outstanding occupancy bookkeeping
          state_n  = HALT;
          md_cnt_n = 6'd0;
        end else if (accepted && id_is_md) begin
          // a fresh mult/div restarts the occupancy window
          state_n  = MD_BUSY;
          md_cnt_n = MD_LAT;
        end else if (md_cnt == 6'd1) begin
          state_n  = RUN;
          md_cnt_n = 6'd0;
        end else begin
          md_cnt_n = md_cnt - 6'd1;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n  = RUN;
        md_cnt_n = 6'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // State, halt flag and performance counter
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= RUN;
      md_cnt       <= 6'd0;
      halted       <= 1'b0;
      stall_cycles <= 32'd0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
      // registered copy of (state == HALT), aligned with the state register
      halted <= (state_n == HALT);
      if (count_stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_LATENCY = 4).
// Each scenario task builds a list of per-cycle stimulus steps; the expected
// {halted, pc_stall, if_id_hold, id_bubble, if_flush} for a cycle is pushed to
// a scoreboard queue as the step is driven and popped when sampled at negedge.
module tb_hazard_ctrl;

  logic        clk;
  logic        clr;
  logic [4:0]  id_read1_num;
  logic [4:0]  id_read2_num;
  logic        id_is_md;
  logic        id_uses_hilo;
  logic        id_is_syscall;
  logic [31:0] v0_value;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_write_num;
  logic        ex_branch_taken;
  logic        pc_stall;
  logic        if_id_hold;
  logic        id_bubble;
  logic        if_flush;
  logic        halted;
  logic [31:0] stall_cycles;

  hazard_ctrl #(.MD_LATENCY(4)) dut (
    .clk            (clk),
    .clr            (clr),
    .id_read1_num   (id_read1_num),
    .id_read2_num   (id_read2_num),
    .id_is_md       (id_is_md),
    .id_uses_hilo   (id_uses_hilo),
    .id_is_syscall  (id_is_syscall),
    .v0_value       (v0_value),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_write_num   (ex_write_num),
    .ex_branch_taken(ex_branch_taken),
    .pc_stall       (pc_stall),
    .if_id_hold     (if_id_hold),
    .id_bubble      (id_bubble),
    .if_flush       (if_flush),
    .halted         (halted),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected {halted, pc_stall, if_id_hold, id_bubble, if_flush}
  localparam logic [4:0] N  = 5'b00000;  // nothing
  localparam logic [4:0] S  = 5'b01110;  // interlock stall
  localparam logic [4:0] F  = 5'b00011;  // branch squash
  localparam logic [4:0] H  = 5'b11110;  // halted, everything held
  localparam logic [4:0] HC = 5'b10000;  // clr cycle while halted

  typedef struct {
    logic [4:0]  r1, r2;
    logic        md, hl, sys;
    logic [31:0] v0;
    logic        mtr;
    logic [4:0]  wn;
    logic        br, rst;
    logic [4:0]  exp;
  } step_t;

  logic [4:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_stalls = 32'd0;

  function automatic step_t stp(int r1, int r2, int md, int hl, int sys, int v0,
                                int mtr, int wn, int br, int rst, logic [4:0] e);
    step_t s;
    s.r1 = 5'(r1); s.r2 = 5'(r2); s.md = 1'(md); s.hl = 1'(hl); s.sys = 1'(sys);
    s.v0 = 32'(v0); s.mtr = 1'(mtr); s.wn = 5'(wn); s.br = 1'(br); s.rst = 1'(rst);
    s.exp = e;
    return s;
  endfunction

  task automatic apply(input step_t s);
    id_read1_num = s.r1;  id_read2_num = s.r2;
    id_is_md = s.md;      id_uses_hilo = s.hl;  id_is_syscall = s.sys;
    v0_value = s.v0;      ex_mem_to_reg = s.mtr; ex_write_num = s.wn;
    ex_branch_taken = s.br; clr = s.rst;
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(8,0,0,0,0,0,1,8,0,1,N));   // clr masks a live load-use
    s.push_back(stp(0,0,0,0,0,0,0,0,0,0,N));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL reset step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls = 32'd0;
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL reset stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_load_use();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(8,0,0,0,0,0,1,8,0,0,S));   // read1 hits load dest
    s.push_back(stp(8,0,0,0,0,0,0,8,0,0,N));   // load moved on: forwarding
    s.push_back(stp(0,5,0,0,0,0,1,5,0,0,S));   // read2 hits
    s.push_back(stp(3,4,0,0,0,0,1,5,0,0,N));   // no match
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL load_use step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls += 32'd2;
    @(posedge clk); #1; apply(stp(0,0,0,0,0,0,0,0,0,0,N));
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL load_use stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_zero_reg();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(0,0,0,0,0,0,1,0,0,0,N));   // load to $zero, readers of $zero
    s.push_back(stp(9,10,0,0,0,0,1,8,0,0,N));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL zero_reg step %0d: got %b expected %b", i, got, e); end
    end
    @(posedge clk); #1; apply(stp(0,0,0,0,0,0,0,0,0,0,N));
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL zero_reg stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_md_latency();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // mult accepted
    for (int k = 0; k < 4; k++) s.push_back(stp(0,0,0,1,0,0,0,0,0,0,S));  // mfhi held
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // mfhi accepted
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // mult again
    for (int k = 0; k < 4; k++) s.push_back(stp(9,10,0,0,0,0,0,0,0,0,N)); // add passes
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // busy window over
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL md_latency step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls += 32'd4;
    @(posedge clk); #1; apply(stp(0,0,0,0,0,0,0,0,0,0,N));
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL md_latency stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // div accepted
    for (int k = 0; k < 4; k++) s.push_back(stp(0,0,1,0,0,0,0,0,0,0,S));  // 2nd div waits
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // 2nd div accepted
    for (int k = 0; k < 4; k++) s.push_back(stp(0,0,0,1,0,0,0,0,0,0,S));
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL back_to_back step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls += 32'd8;
    @(posedge clk); #1; apply(stp(0,0,0,0,0,0,0,0,0,0,N));
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL back_to_back stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_branch();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(8,0,0,0,0,0,1,8,1,0,F));             // branch beats load-use
    s.push_back(stp(0,0,1,0,0,0,0,0,1,0,F));             // squashed mult
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // so mfhi is free
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // real mult
    s.push_back(stp(0,0,0,1,0,0,0,0,1,0,F));             // branch inside busy window
    for (int k = 0; k < 3; k++) s.push_back(stp(0,0,0,1,0,0,0,0,0,0,S));  // still busy
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL branch step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls += 32'd3;
    @(posedge clk); #1; apply(stp(0,0,0,0,0,0,0,0,0,0,N));
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL branch stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_halt();
    step_t s[$];
    logic [4:0] got, e;
    logic [31:0] pre_clr;
    s.push_back(stp(0,0,0,0,1,1,0,0,0,0,N));             // syscall, v0=1
    s.push_back(stp(0,0,0,0,0,0,0,0,0,0,N));             // no halt
    s.push_back(stp(8,0,0,0,1,10,1,8,0,0,S));            // exit syscall interlocked
    s.push_back(stp(0,0,0,0,1,10,0,0,1,0,F));            // exit syscall squashed
    s.push_back(stp(0,0,0,0,0,0,0,0,0,0,N));
    s.push_back(stp(0,0,0,0,1,10,0,0,0,0,N));            // exit accepted
    for (int k = 0; k < 20; k++)
      s.push_back(stp(8,0,0,0,0,0,(k%3==1),8,(k%3==0),0,H));
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL halt step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls += 32'd1;                                  // only the interlocked syscall
    pre_clr = stall_cycles;
    checks++;
    if (pre_clr !== exp_stalls) begin errors++; $display("FAIL halt stall_cycles: got %0d expected %0d", pre_clr, exp_stalls); end
    s.delete();
    s.push_back(stp(8,0,0,0,0,0,1,8,0,1,HC));            // clr cycle
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // running again
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL halt_clr step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls = 32'd0;
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL halt_clr stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  task automatic test_syscall_in_md();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // mult accepted
    s.push_back(stp(0,0,0,0,1,10,0,0,0,0,N));            // exit during busy window
    s.push_back(stp(0,0,0,0,0,0,0,0,0,0,H));
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,H));
    s.push_back(stp(0,0,0,0,0,0,0,0,0,1,HC));
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // no residual busy after clr
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL syscall_in_md step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls = 32'd0;
  endtask

  task automatic test_clr_md();
    step_t s[$];
    logic [4:0] got, e;
    s.push_back(stp(0,0,1,0,0,0,0,0,0,0,N));             // div accepted
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,S));             // mflo stalled
    s.push_back(stp(0,0,0,1,0,0,0,0,0,1,N));             // clr: outputs quiet
    s.push_back(stp(0,0,0,1,0,0,0,0,0,0,N));             // mflo goes
    foreach (s[i]) begin
      @(posedge clk); #1; apply(s[i]); sb_q.push_back(s[i].exp);
      @(negedge clk); e = sb_q.pop_front();
      got = {halted, pc_stall, if_id_hold, id_bubble, if_flush};
      checks++;
      if (got !== e) begin errors++; $display("FAIL clr_md step %0d: got %b expected %b", i, got, e); end
    end
    exp_stalls = 32'd0;
    checks++;
    if (stall_cycles !== exp_stalls) begin errors++; $display("FAIL clr_md stall_cycles: got %0d expected %0d", stall_cycles, exp_stalls); end
  endtask

  initial begin
    apply(stp(0,0,0,0,0,0,0,0,0,1,N));
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_zero_reg();
    test_md_latency();
    test_back_to_back();
    test_branch();
    test_halt();
    test_syscall_in_md();
    test_clr_md();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It decides each cycle whether the IF stage and PC hold, whether the ID/WB stage inserts a bubble (drives its `stall` input), and whether IF is flushed. It handles four conditions:

- load-use interlocks
- multi-cycle multiply/divide occupancy
- taken-branch squashes
- the exit syscall (`$v0 == 10`), which halts the core

It also keeps a stall-cycle counter for performance measurement.

## Interface
Parameters:
- `MD_LATENCY`, default 4: cycles HI/LO stays busy after a mult/div leaves ID. Legal range 1..63.

Ports:
- `clk`  in  1  core clock; the only clock.
- `clr`  in  1  reset; synchronous, active-high.
- `id_read1_num`  in  5  ID read-port-1 register number (realtime, 0 when unused).
- `id_read2_num`  in  5  ID read-port-2 register number (realtime, 0 when unused).
- `id_is_md`  in  1  instruction in ID is mult/multu/div/divu.
- `id_uses_hilo`  in  1  instruction in ID is mfhi/mflo/mthi/mtlo.
- `id_is_syscall`  in  1  instruction in ID is syscall.
- `v0_value`  in  32  forwarded value of `$v0` for the instruction in ID.
- `ex_mem_to_reg`  in  1  instruction in EX is a load.
- `ex_write_num`  in  5  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `pc_stall`  out  1  hold PC.
- `if_id_hold`  out  1  hold the IF output latch.
- `id_bubble`  out  1  drives the ID/WB stage `stall`; replaces the ID output with a NOP.
- `if_flush`  out  1  clear the IF output latch to NOP.
- `halted`  out  1  core halted by the exit syscall.
- `stall_cycles`  out  32  count of interlock stall cycles.

## Operation
- State register values: `RUN`, `MD_BUSY`, `HALT`. The block also holds a 6-bit `md_cnt`.
- Hazard terms:
  - `lu` = `ex_mem_to_reg` && `ex_write_num` != 0 && (`ex_write_num` == `id_read1_num` || `ex_write_num` == `id_read2_num`).
  - `md` = state == `MD_BUSY` && (`id_uses_hilo` || `id_is_md`).
- Output priority, highest first:
  1. `HALT`: `pc_stall` = `if_id_hold` = `id_bubble` = 1, `if_flush` = 0.
  2. `ex_branch_taken`: `if_flush` = 1, `id_bubble` = 1, `pc_stall` = `if_id_hold` = 0. The stalled instruction is wrong-path, so the branch overrides `lu` and `md`.
  3. `lu` || `md`: `pc_stall` = `if_id_hold` = `id_bubble` = 1, `if_flush` = 0.
  4. Otherwise all outputs 0.
- "Accepted" means: state != `HALT`, no `ex_branch_taken`, no `lu`, no `md`.
- Transitions:
  - `RUN` → `MD_BUSY` when `id_is_md` is accepted. `md_cnt` loads `MD_LATENCY`.
  - `MD_BUSY` → `MD_BUSY`: `md_cnt` decrements every cycle.
    - When `md_cnt` == 1, next state is `RUN` and `md_cnt` becomes 0.
    - If a new `id_is_md` is accepted on that same cycle (only possible when not stalled), next state stays `MD_BUSY` and `md_cnt` reloads `MD_LATENCY`.
  - `RUN`/`MD_BUSY` → `HALT` when `id_is_syscall` is accepted and `v0_value` == 32'd10. The syscall takes precedence over any `MD_BUSY` bookkeeping.
  - A syscall with any other `v0_value` has no effect here.
  - `HALT` is exited only by `clr`.
- A taken branch does not cancel `MD_BUSY`; the mult/div in EX or beyond is older than the branch. A squashed `id_is_md` is not accepted.
- `stall_cycles` increments on each cycle where (`lu` || `md`) causes `pc_stall`, excluding `HALT` and branch cycles. It saturates at 32'hFFFFFFFF.

## Timing
- `pc_stall`, `if_id_hold`, `id_bubble` and `if_flush` are combinational from the current inputs and state, effective in the same cycle.
- `halted` is registered: `halted` = (state == `HALT`). It asserts the cycle after the syscall is accepted.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM and forwarding covers it.
- After an mult/div is accepted at edge E, HI/LO users in ID stall for cycles E+1 .. E+`MD_LATENCY` and are accepted in cycle E+`MD_LATENCY`+1.
- Behaviour in a cycle where `clr` = 1:
  - All combinational outputs are 0.
  - At the edge: state = `RUN`, `md_cnt` = 0, `halted` = 0, `stall_cycles` = 0.
  - `clr` mid-`MD_BUSY` or mid-`HALT` returns to `RUN` with no residual stall.
- Reset values: all outputs 0.

## Test plan
- Load-use: `ex_mem_to_reg` = 1, `ex_write_num` = 8, `id_read1_num` = 8 → that cycle `pc_stall` = `if_id_hold` = `id_bubble` = 1. Next cycle (`ex_mem_to_reg` = 0) all 0. `stall_cycles` = 1.
- `$zero` exemption: load to reg 0 with `id_read2_num` = 0 → no stall, `stall_cycles` unchanged.
- Mult/div latency (`MD_LATENCY` = 4):
  - mult accepted, then mfhi held in ID → stalled exactly 4 cycles, accepted in the 5th.
  - An add (reads 9/10) in ID during `MD_BUSY` → no stall.
- Branch versus stall: `ex_branch_taken` = 1 together with a load-use match → `if_flush` = 1, `id_bubble` = 1, `pc_stall` = 0, `stall_cycles` unchanged.
- Halt: syscall with `v0_value` = 10 → `halted` = 1 on the next cycle, all stalls held for 20 cycles.
  - Assert `clr` → `halted` = 0, `stall_cycles` = 0.
  - Syscall with `v0_value` = 1 → no halt.
- Reset mid-`MD_BUSY`: `clr` 2 cycles after a div is accepted → the cycle after `clr`, mflo in ID is not stalled.
